// File: rtl/pga_pkg.sv
// Shared encodings for the MCP6S2x multi-device PGA controller:
// request commands, instruction opcodes, FSM states and frame builder.
package pga_pkg;

    typedef enum logic [1:0] {
        CMD_GAIN = 2'd0,
        CMD_CHAN = 2'd1,
        CMD_SHDN = 2'd2,
        CMD_NOP  = 2'd3
    } cmd_e;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SHIFT,
        ST_ENDF,
        ST_GAP
    } state_e;

    localparam logic [7:0] OP_GAIN = 8'h40;
    localparam logic [7:0] OP_CHAN = 8'h41;
    localparam logic [7:0] OP_SHDN = 8'h20;
    localparam logic [7:0] OP_NOP  = 8'h00;

    function automatic logic [15:0] build_frame(
        input cmd_e       cmd,
        input logic [2:0] data
    );
        logic [15:0] f;
        f = '0;
        unique case (cmd)
            CMD_GAIN: f = {OP_GAIN, 5'b0, data};
            CMD_CHAN: f = {OP_CHAN, 5'b0, data};
            CMD_SHDN: f = {OP_SHDN, 8'h00};
            CMD_NOP:  f = {OP_NOP, 8'h00};
            default:  f = '0;
        endcase
        return f;
    endfunction

endpackage

// File: rtl/pga_multi_ctrl_if.sv
// Request handshake plus SPI pins of the PGA controller.
// master = requester side, slave = controller side.
interface pga_multi_ctrl_if #(
    parameter int NUM_DEV = 2
);
    localparam int DW = (NUM_DEV > 1) ? $clog2(NUM_DEV) : 1;

    logic               Req_Valid;
    logic               Req_Ready;
    logic [DW-1:0]      Req_Dev;
    logic [1:0]         Req_Cmd;
    logic [2:0]         Req_Data;
    logic               Busy;
    logic               Done;
    logic               Err;
    logic [NUM_DEV-1:0] SPI_nCS;
    logic               SPI_SO;
    logic               SPI_SCK;

    modport master (
        output Req_Valid, Req_Dev, Req_Cmd, Req_Data,
        input  Req_Ready, Busy, Done, Err,
        input  SPI_nCS, SPI_SO, SPI_SCK
    );

    modport slave (
        input  Req_Valid, Req_Dev, Req_Cmd, Req_Data,
        output Req_Ready, Busy, Done, Err,
        output SPI_nCS, SPI_SO, SPI_SCK
    );

endinterface

// File: rtl/pga_tick_gen.sv
// Divide-by-CLK_DIV tick source with synchronous clear; tick fires on the
// last count, pre_tick one clock earlier.
module pga_tick_gen #(
    parameter int CLK_DIV = 50
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    output logic tick,
    output logic pre_tick
);
    localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(CLK_DIV - 1);
    localparam logic [CW-1:0] PRE  = CW'(CLK_DIV - 2);

    logic [CW-1:0] cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (clear || cnt == LAST) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

    assign tick     = !clear && (cnt == LAST);
    assign pre_tick = !clear && (cnt == PRE);

endmodule

// File: rtl/pga_multi_ctrl.sv
// SPI frame controller for NUM_DEV MCP6S2x PGAs: one 16-bit write per
// accepted request, SPI mode 0, chip-select gap between frames.
module pga_multi_ctrl
    import pga_pkg::*;
#(
    parameter int CLK_DIV = 50,
    parameter int NUM_DEV = 2,
    parameter int CS_GAP  = 2
) (
    input logic             Clk,
    input logic             Reset,
    pga_multi_ctrl_if.slave bus
);
    localparam int DW = (NUM_DEV > 1) ? $clog2(NUM_DEV) : 1;
    localparam int TW = $clog2(CS_GAP + 40);
    localparam logic [TW-1:0] T_LAST_BIT = TW'(31);
    localparam logic [TW-1:0] T_GAP_END  = TW'(32 + CS_GAP);
    localparam logic [DW:0]   DEV_LIM    = (DW + 1)'(NUM_DEV);

    if (CLK_DIV < 2) begin : g_bad_div
        $error("pga_multi_ctrl: CLK_DIV must be >= 2");
    end
    if (NUM_DEV < 1) begin : g_bad_dev
        $error("pga_multi_ctrl: NUM_DEV must be >= 1");
    end
    if (CS_GAP < 1) begin : g_bad_gap
        $error("pga_multi_ctrl: CS_GAP must be >= 1");
    end

    state_e             state;
    state_e             state_nx;
    logic               armed;
    logic               err_q;
    logic               tick;
    logic               pre_tick;
    logic               accept;
    logic               dev_ok;
    logic [TW-1:0]      tcnt;
    logic [15:0]        frame;
    logic [DW-1:0]      dev;
    logic               sel;
    logic [NUM_DEV-1:0] ncs;
    logic               sck;
    logic               so;
    logic               done;
    logic               ready;

    assign accept = bus.Req_Valid && ready;
    assign dev_ok = {1'b0, bus.Req_Dev} < DEV_LIM;

    pga_tick_gen #(
        .CLK_DIV(CLK_DIV)
    ) u_tick (
        .clk     (Clk),
        .rst     (Reset),
        .clear   (state == ST_IDLE),
        .tick    (tick),
        .pre_tick(pre_tick)
    );

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // GAP leaves one clock before the final gap tick so the next request
    // can be taken exactly on that tick edge.
    always_comb begin
        state_nx = state;
        unique case (state)
            ST_IDLE:  if (accept && dev_ok) state_nx = ST_SHIFT;
            ST_SHIFT: if (tick && tcnt == T_LAST_BIT) state_nx = ST_ENDF;
            ST_ENDF:  if (tick) state_nx = ST_GAP;
            ST_GAP:   if (pre_tick && tcnt == T_GAP_END) state_nx = ST_IDLE;
            default:  state_nx = ST_IDLE;
        endcase
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            armed <= 1'b0;
            err_q <= 1'b0;
            tcnt  <= '0;
            frame <= '0;
            dev   <= '0;
        end else begin
            armed <= 1'b1;
            err_q <= accept && !dev_ok;
            if (state == ST_IDLE) begin
                tcnt <= '0;
            end else if (tick) begin
                tcnt <= tcnt + 1'b1;
            end
            if (accept && dev_ok) begin
                frame <= build_frame(cmd_e'(bus.Req_Cmd), bus.Req_Data);
                dev   <= bus.Req_Dev;
            end
        end
    end

    // Odd tick counts are SCK-high phases; bit index advances every 2 ticks.
    always_comb begin
        sel = (state == ST_SHIFT) || (state == ST_ENDF);
        for (int i = 0; i < NUM_DEV; i++) begin
            ncs[i] = !(sel && dev == DW'(i));
        end
        sck   = (state == ST_SHIFT) && tcnt[0];
        so    = (state == ST_SHIFT) && frame[4'd15 - tcnt[4:1]];
        done  = (state == ST_ENDF) && tick;
        ready = armed && (state == ST_IDLE);
    end

    assign bus.Req_Ready = ready;
    assign bus.Busy      = !Reset && !ready;
    assign bus.Done      = done;
    assign bus.Err       = err_q;
    assign bus.SPI_nCS   = ncs;
    assign bus.SPI_SO    = so;
    assign bus.SPI_SCK   = sck;

endmodule

// File: tb/tb_pga_multi_ctrl.sv
// Randomized self-checking bench for pga_multi_ctrl: frames, timing,
// busy-drop, bad-device reject and mid-frame reset.
module tb_pga_multi_ctrl;
    localparam int DIV = 4;
    localparam int GAP = 2;

    logic Clk = 1'b0;
    logic Reset = 1'b1;
    int   n_chk = 0;
    int   n_pass = 0;

    always #5 Clk = ~Clk;

    pga_multi_ctrl_if #(.NUM_DEV(2)) a ();
    pga_multi_ctrl_if #(.NUM_DEV(3)) b ();

    pga_multi_ctrl #(
        .CLK_DIV(DIV), .NUM_DEV(2), .CS_GAP(GAP)
    ) dut_a (
        .Clk(Clk), .Reset(Reset), .bus(a)
    );

    pga_multi_ctrl #(
        .CLK_DIV(DIV), .NUM_DEV(3), .CS_GAP(GAP)
    ) dut_b (
        .Clk(Clk), .Reset(Reset), .bus(b)
    );

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    function automatic logic [15:0] exp_frame(input int cmd, input int data);
        case (cmd)
            0:       return 16'h4000 | 16'(data & 7);
            1:       return 16'h4100 | 16'(data & 7);
            2:       return 16'h2000;
            default: return 16'h0000;
        endcase
    endfunction

    // Call at a negedge; returns at the negedge where Req_Ready is back.
    // e counts the rising edge that will sample the current values (E0 = 0).
    task automatic send(input int dev, input int cmd, input int data,
                        input bit hold, input bit poke);
        int w = 0;
        int sck_n = 0;
        int done_n = 0;
        int done_at = 0;
        int rdy_at = 0;
        int other_lo = 0;
        int tgt_lo = 0;
        int hi_n = 0;
        int bad = 0;
        logic [15:0] got = '0;
        logic prev = 1'b0;
        while (!a.Req_Ready && w < 400) begin
            @(negedge Clk);
            w++;
        end
        chk("ready_wait", 32'(w < 400), 1);
        a.Req_Valid = 1'b1;
        a.Req_Dev   = 1'(dev);
        a.Req_Cmd   = 2'(cmd);
        a.Req_Data  = 3'(data);
        @(negedge Clk);
        if (!hold) begin
            a.Req_Valid = 1'b0;
            a.Req_Dev   = ~a.Req_Dev;
            a.Req_Cmd   = 2'($urandom);
            a.Req_Data  = 3'($urandom);
        end
        for (int e = 1; e <= 400; e++) begin
            if (poke && e == 40) begin
                a.Req_Valid = 1'b1;
                a.Req_Dev   = 1'(1 - dev);
            end
            if (poke && e == 42) a.Req_Valid = 1'b0;
            if (a.SPI_SCK && !prev) begin
                sck_n++;
                got = {got[14:0], a.SPI_SO};
            end
            prev = a.SPI_SCK;
            if (a.Done) begin
                done_n++;
                done_at = e;
            end
            if (!a.SPI_nCS[1 - dev]) other_lo++;
            if (!a.SPI_nCS[dev]) tgt_lo++;
            if (a.SPI_nCS == 2'b00) bad++;
            if (a.SPI_nCS == 2'b11 && a.SPI_SCK) bad++;
            if (a.Busy == a.Req_Ready) bad++;
            if (e == 33 * DIV - 2 && (a.SPI_SO || a.SPI_nCS[dev])) bad++;
            if (a.SPI_nCS == 2'b11 && done_n > 0) hi_n++;
            if (a.Req_Ready) begin
                rdy_at = e;
                break;
            end
            @(negedge Clk);
        end
        chk("frame_bits", got, exp_frame(cmd, data));
        chk("sck_rises", sck_n, 16);
        chk("done_count", done_n, 1);
        chk("done_edge", done_at, 33 * DIV);
        chk("ready_edge", rdy_at, (33 + GAP) * DIV);
        chk("other_cs_low", other_lo, 0);
        chk("target_cs_len", tgt_lo, 33 * DIV);
        chk("gap_cs_high", hi_n, GAP * DIV);
        chk("protocol", bad, 0);
    endtask

    task automatic quiet(input int n);
        int lo = 0;
        int dn = 0;
        for (int i = 0; i < n; i++) begin
            @(negedge Clk);
            if (a.SPI_nCS != 2'b11) lo++;
            if (a.Done) dn++;
        end
        chk("quiet_cs", lo, 0);
        chk("quiet_done", dn, 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        int lo;
        int dn;
        int er;
        int nr;
        a.Req_Valid = 1'b0;
        a.Req_Dev = '0;
        a.Req_Cmd = '0;
        a.Req_Data = '0;
        b.Req_Valid = 1'b0;
        b.Req_Dev = '0;
        b.Req_Cmd = '0;
        b.Req_Data = '0;

        repeat (3) @(posedge Clk);
        #1;
        chk("rst_ncs", a.SPI_nCS, 2'b11);
        chk("rst_sck", a.SPI_SCK, 0);
        chk("rst_so", a.SPI_SO, 0);
        chk("rst_done", a.Done, 0);
        chk("rst_err", a.Err, 0);
        chk("rst_busy", a.Busy, 0);
        chk("rst_ready", a.Req_Ready, 0);
        chk("rst_ncs_b", b.SPI_nCS, 3'b111);
        @(negedge Clk);
        Reset = 1'b0;
        #1;
        chk("ready_before_edge", a.Req_Ready, 0);
        @(posedge Clk);
        #1;
        chk("ready_after_edge", a.Req_Ready, 1);
        chk("busy_idle", a.Busy, 0);
        @(negedge Clk);

        send(0, 0, 5, 1'b0, 1'b0);
        send(1, 1, 6, 1'b0, 1'b0);
        send(0, 2, int'($urandom_range(0, 7)), 1'b0, 1'b1);
        quiet(200);

        b.Req_Valid = 1'b1;
        b.Req_Dev   = 2'd3;
        b.Req_Cmd   = 2'($urandom);
        b.Req_Data  = 3'($urandom);
        @(negedge Clk);
        chk("err_pulse", b.Err, 1);
        chk("err_ready", b.Req_Ready, 1);
        chk("err_ncs", b.SPI_nCS, 3'b111);
        b.Req_Valid = 1'b0;
        lo = 0;
        dn = 0;
        er = 0;
        nr = 0;
        for (int i = 0; i < 150; i++) begin
            @(negedge Clk);
            if (b.SPI_nCS != 3'b111) lo++;
            if (b.Done) dn++;
            if (b.Err) er++;
            if (!b.Req_Ready) nr++;
        end
        chk("err_cs_quiet", lo, 0);
        chk("err_no_done", dn, 0);
        chk("err_one_cycle", er, 0);
        chk("err_ready_kept", nr, 0);

        send(0, 0, 3, 1'b1, 1'b0);
        send(0, 0, 3, 1'b0, 1'b0);

        for (int k = 0; k < 6; k++) begin
            send(int'($urandom_range(0, 1)), int'($urandom_range(0, 3)),
                 int'($urandom_range(0, 7)), 1'b0, 1'b0);
        end

        a.Req_Valid = 1'b1;
        a.Req_Dev   = 1'b1;
        a.Req_Cmd   = 2'd0;
        a.Req_Data  = 3'd2;
        @(negedge Clk);
        a.Req_Valid = 1'b0;
        repeat (39) @(negedge Clk);
        chk("pre_rst_ncs", a.SPI_nCS, 2'b01);
        @(posedge Clk);
        #1 Reset = 1'b1;
        #1;
        chk("abort_ncs", a.SPI_nCS, 2'b11);
        chk("abort_sck", a.SPI_SCK, 0);
        chk("abort_so", a.SPI_SO, 0);
        chk("abort_busy", a.Busy, 0);
        chk("abort_ready", a.Req_Ready, 0);
        dn = 0;
        for (int i = 0; i < 3; i++) begin
            @(negedge Clk);
            if (a.Done) dn++;
        end
        chk("abort_no_done", dn, 0);
        Reset = 1'b0;
        #1;
        chk("rel_ready_low", a.Req_Ready, 0);
        @(posedge Clk);
        #1;
        chk("rel_ready_high", a.Req_Ready, 1);
        @(negedge Clk);
        send(0, 0, 7, 1'b0, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/pga_multi_ctrl.md
PGA_MULTI_CTRL -- requirements
Module: pga_multi_ctrl

Interface
REQ-001 SHALL have parameter CLK_DIV, default 50: Clk cycles per SPI half-period tick; legal range >= 2.
REQ-002 SHALL have parameter NUM_DEV, default 2: number of MCP6S2x devices, one chip select each; legal range >= 1.
REQ-003 SHALL have parameter CS_GAP, default 2: idle ticks with all chip selects high between frames; legal range >= 1.
REQ-004 SHALL use one clock and an asynchronous, active-high reset, with these ports:
- Clk  in  1  sole clock.
- Reset  in  1  asynchronous, active-high reset.
- Req_Valid  in  1  request present.
- Req_Ready  out  1  block can accept a request.
- Req_Dev  in  DW=max(1,$clog2(NUM_DEV))  target device index.
- Req_Cmd  in  2  request command: 0 = gain write, 1 = channel write, 2 = shutdown, 3 = NOP.
- Req_Data  in  3  gain code or channel number.
- Busy  out  1  frame or gap in progress.
- Done  out  1  one-cycle pulse when a frame completes.
- Err  out  1  one-cycle pulse when a request is rejected.
- SPI_nCS  out  NUM_DEV  active-low chip selects.
- SPI_SO  out  1  serial data, MSB first.
- SPI_SCK  out  1  serial clock, SPI mode 0.

Function
REQ-005 SHALL accept a request on a rising Clk edge where Req_Valid && Req_Ready (edge E0), and SHALL capture Req_Dev, Req_Cmd and Req_Data at E0; later input changes SHALL NOT affect the frame.
REQ-006 SHALL build a 16-bit frame and send it MSB first:
- Gain write: 0x40, then {5'b0, Data}.
- Channel write: 0x41, then {5'b0, Data}.
- Shutdown: 0x20, then 0x00.
- NOP: 0x00, then 0x00.
REQ-007 SHALL derive ticks from an internal divider: cleared at E0, tick k occurring at edge E0 + k*CLK_DIV; no derived clocks.
REQ-008 SHALL run the state machine IDLE -> SHIFT -> ENDF -> GAP -> IDLE.
REQ-009 At E0, SHALL drive SPI_nCS[Dev] low, SPI_SO to frame bit 15, and SPI_SCK low, and enter SHIFT.
REQ-010 In SHIFT, for i = 1..16, SHALL raise SPI_SCK at tick 2i-1, and at tick 2i lower SPI_SCK and present the next bit; SPI_SO SHALL be 0 after tick 32, and the state SHALL become ENDF at tick 32.
REQ-011 At tick 33, SHALL set all SPI_nCS high, pulse Done for exactly one Clk cycle, and enter GAP.
REQ-012 SHALL stay in GAP for CS_GAP ticks, then return to IDLE; Req_Ready SHALL return high at edge E0 + (33+CS_GAP)*CLK_DIV.
REQ-013 Req_Ready SHALL be high only in IDLE; Busy SHALL equal !Req_Ready outside reset.
REQ-014 Req_Valid while busy SHALL be ignored; no request is queued.
REQ-015 If Req_Dev >= NUM_DEV at acceptance, SHALL pulse Err one cycle after E0, send no frame, leave Done low, and stay in IDLE.
REQ-016 At most one SPI_nCS bit SHALL be low at any time.
REQ-017 SPI_SCK SHALL be low whenever all SPI_nCS are high.

Reset
REQ-018 While Reset is high, SHALL hold:
- SPI_nCS all 1.
- SPI_SCK, SPI_SO, Done, Err, Busy = 0.
- Req_Ready = 0.
- State IDLE, divider 0.
REQ-019 Reset asserted mid-frame SHALL abort the frame immediately (asynchronously), with no Done pulse.
REQ-020 Req_Ready SHALL go high on the first Clk edge after Reset deasserts.

Structure
REQ-021 SHALL take the command encoding, the instruction opcodes (0x40, 0x41, 0x20, 0x00) and the state enum from shared package pga_pkg.
REQ-022 SHALL instantiate sub-module pga_tick_gen (parametrised CLK_DIV counter with synchronous clear, emitting a one-cycle tick); all other logic SHALL be inline.
REQ-023 SHALL reject illegal parameter values (CLK_DIV < 2, NUM_DEV < 1, CS_GAP < 1) at elaboration.

Verification
REQ-024 SHALL pass, with CLK_DIV=4, NUM_DEV=2, CS_GAP=2: gain write, Dev 0, Data 5 -> SO bytes 0x40, 0x05 sampled on SCK rising edges; nCS[1] stays high; Done high for one cycle at edge E0+132; Req_Ready high at edge E0+140.
REQ-025 SHALL pass: channel write, Dev 1, Data 6 -> SO bytes 0x41, 0x06 on nCS[1]; 16 SCK rising edges; nCS[0] stays high.
REQ-026 SHALL pass: shutdown, Dev 0 -> SO bytes 0x20, 0x00; in the same run, Req_Valid pulsed mid-frame with Dev 1 -> ignored, no second frame.
REQ-027 SHALL pass, with NUM_DEV=3: request with Dev 3 -> Err pulse one cycle after E0, all nCS stay high, no Done, Req_Ready stays high.
REQ-028 SHALL pass: Req_Valid held high for two gain writes -> second E0 at first E0+140, two complete frames, two Done pulses, nCS high for at least 8 Clk cycles between frames.
REQ-029 SHALL pass: Reset asserted at tick 10 of a frame -> nCS all high, SCK 0, SO 0 immediately, no Done; after release, a new gain write completes normally.
